// File: rtl/bcd_updown_counter_n.sv
// Cascaded N-digit BCD up/down counter with a range-checked parallel load and terminal-count and error pulses.
// Define BCD_CNT_SATURATE_EN to hold at the boundaries instead of wrapping.
module bcd_updown_counter_n #(
    parameter int DIGITS = 2,
    parameter int TOP    = 99
) (
    input  logic                  clk_1Hz,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  load,
    input  logic                  type_sel,
    input  logic [4*DIGITS-1:0]   in,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // The carry ripples combinationally through all digits, so every step completes in one edge.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] TOP_BCD = to_bcd(TOP);

    logic [W-1:0] step_q;
    logic         at_bound;
    logic         load_ok;

    // With all digits valid, BCD magnitude order equals binary order, so a plain compare works.
    always_comb begin
        load_ok  = bcd_valid(in) && (in <= TOP_BCD);
        at_bound = type_sel ? (q == '0) : (q == TOP_BCD);
        step_q   = q;
        if (at_bound) begin
`ifdef BCD_CNT_SATURATE_EN
            step_q = q;
`else
            step_q = type_sel ? TOP_BCD : '0;
`endif
        end else begin
            step_q = type_sel ? bcd_dec(q) : bcd_inc(q);
        end
    end

    always_ff @(posedge clk_1Hz or posedge clr) begin
        if (clr) begin
            q   <= '0;
            tc  <= 1'b0;
            err <= 1'b0;
        end else begin
            tc  <= 1'b0;
            err <= 1'b0;
            if (load) begin
                if (load_ok) q   <= in;
                else         err <= 1'b1;
            end else if (en) begin
                q  <= step_q;
                tc <= at_bound;
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench for bcd_updown_counter_n: a decimal reference model pushes expected q/tc/err per edge.
module tb_bcd_updown_counter_n;

`ifdef BCD_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int TOPA = 59;
    localparam int TOPB = 999;

    logic        clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    logic        clr, en, load, type_sel;
    logic [7:0]  in;
    logic [7:0]  q;
    logic        tc, err;

    logic        en_b, type_b, load_b;
    logic [11:0] in_b;
    logic [11:0] q_b;
    logic        tc_b, err_b;

    bcd_updown_counter_n #(.DIGITS(2), .TOP(TOPA)) dut_a (
        .clk_1Hz(clk_1Hz), .clr(clr), .en(en), .load(load), .type_sel(type_sel),
        .in(in), .q(q), .tc(tc), .err(err)
    );

    bcd_updown_counter_n #(.DIGITS(3), .TOP(TOPB)) dut_b (
        .clk_1Hz(clk_1Hz), .clr(clr), .en(en_b), .load(load_b), .type_sel(type_b),
        .in(in_b), .q(q_b), .tc(tc_b), .err(err_b)
    );

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       tc;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   model_v    = 0;
    int   model_b    = 0;
    int   tc_seen    = 0;
    logic last_tc;

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] bcd3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t x;
        if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        x = sbq.pop_front();
        check({x.tag, "_q"},   12'(q),   12'(x.q));
        check({x.tag, "_tc"},  12'(tc),  12'(x.tc));
        check({x.tag, "_err"}, 12'(err), 12'(x.err));
        last_tc = tc;
    endtask

    // One clock edge on dut_a: drive at negedge, predict, compare after the posedge.
    task automatic drive(input logic l, input logic e, input logic t, input logic [7:0] d, input string tag);
        exp_t x;
        int   hi, lo;
        @(negedge clk_1Hz);
        load = l; en = e; type_sel = t; in = d;
        hi = int'(d[7:4]);
        lo = int'(d[3:0]);
        x.tc  = 1'b0;
        x.err = 1'b0;
        if (l) begin
            if (hi <= 9 && lo <= 9 && hi * 10 + lo <= TOPA) model_v = hi * 10 + lo;
            else x.err = 1'b1;
        end else if (e) begin
            if (!t) begin
                if (model_v == TOPA) begin x.tc = 1'b1; if (!SAT) model_v = 0; end
                else model_v++;
            end else begin
                if (model_v == 0) begin x.tc = 1'b1; if (!SAT) model_v = TOPA; end
                else model_v--;
            end
        end
        x.q   = bcd2(model_v);
        x.tag = tag;
        sbq.push_back(x);
        @(posedge clk_1Hz);
        #1;
        pop_check();
        @(negedge clk_1Hz);
        load = 1'b0; en = 1'b0;
    endtask

    // clr pulse strictly between edges; outputs must clear without any clock edge.
    task automatic clr_pulse(input string tag);
        @(negedge clk_1Hz);
        #1 clr = 1'b1;
        #1;
        check({tag, "_q"},   12'(q),   12'h000);
        check({tag, "_tc"},  12'(tc),  12'h000);
        check({tag, "_err"}, 12'(err), 12'h000);
        #1 clr = 1'b0;
        model_v = 0;
        model_b = 0;
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; load = 1'b0; type_sel = 1'b0; in = 8'h00;
        en_b = 1'b0; type_b = 1'b0; load_b = 1'b0; in_b = 12'h000;
        @(posedge clk_1Hz);
        #1;
        check("reset_q",   12'(q),   12'h000);
        check("reset_tc",  12'(tc),  12'h000);
        check("reset_err", 12'(err), 12'h000);
        check("reset_qb",  q_b,      12'h000);
        @(negedge clk_1Hz);
        clr = 1'b0;

        drive(1, 0, 0, 8'h09, "load09");
        drive(0, 1, 0, 8'h00, "up_carry");
        check("up_carry_const", 12'(q), 12'h010);

        drive(1, 0, 0, 8'h58, "load58");
        drive(0, 1, 0, 8'h00, "up_58");
        drive(0, 1, 0, 8'h00, "up_59");
        drive(0, 1, 0, 8'h00, "up_after");

        clr_pulse("clr_a");
        drive(0, 1, 1, 8'h00, "down_bound");
        drive(0, 1, 1, 8'h00, "down_after");

        drive(1, 0, 0, 8'h3A, "rej_3A");
        drive(0, 0, 0, 8'h00, "hold_after_rej");
        drive(1, 1, 0, 8'h60, "rej_60");
        drive(1, 0, 0, 8'h42, "load42");
        check("load42_const", 12'(q), 12'h042);
        drive(1, 1, 0, 8'h07, "prio_load");
        check("prio_const", 12'(q), 12'h007);
        drive(0, 1, 0, 8'h00, "type_up");
        drive(0, 1, 1, 8'h00, "type_down");

        drive(1, 0, 0, 8'h33, "load33");
        clr_pulse("clr_at33");
        drive(1, 0, 0, 8'h59, "load59");
        drive(0, 1, 0, 8'h00, "wrap_tc");
        clr_pulse("clr_mid_wrap");
        drive(1, 0, 0, 8'h9F, "rej_9F");
        clr_pulse("clr_mid_err");

        // clr held across an edge must swallow load and en.
        @(negedge clk_1Hz);
        clr = 1'b1; load = 1'b1; en = 1'b1; in = 8'h42;
        @(posedge clk_1Hz);
        #1;
        check("clr_held_q",   12'(q),   12'h000);
        check("clr_held_err", 12'(err), 12'h000);
        @(negedge clk_1Hz);
        clr = 1'b0; load = 1'b0; en = 1'b0;
        model_v = 0;
        drive(0, 1, 0, 8'h00, "resume_first_edge");
        clr_pulse("clr_pre_sweep");

        tc_seen = 0;
        for (int i = 0; i < 60; i++) begin
            drive(0, 1, 0, 8'h00, "sweep2");
            if (last_tc) tc_seen++;
        end
        check("sweep2_tc_count", 12'(tc_seen), 12'd1);

        tc_seen = 0;
        model_b = 0;
        @(negedge clk_1Hz);
        en_b = 1'b1; type_b = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic exp_tc;
            exp_tc = 1'b0;
            if (model_b == TOPB) begin exp_tc = 1'b1; if (!SAT) model_b = 0; end
            else model_b++;
            @(posedge clk_1Hz);
            #1;
            check("sweep3_q",  q_b,         bcd3(model_b));
            check("sweep3_tc", 12'(tc_b),   12'(exp_tc));
            if (tc_b) tc_seen++;
        end
        @(negedge clk_1Hz);
        en_b = 1'b0;
        check("sweep3_tc_count", 12'(tc_seen), 12'd1);
        check("sweep3_err",      12'(err_b),   12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
